bufg_gt_div_ctrl: RTL
=====================

Name: bufg_gt_div_ctrl

Overview:
Control sequencer that drives the CE, CLR and DIV inputs of the BUFG_GT clock-buffer model in the xilinx2asic layer. It runs in the reference clock domain that feeds the buffer's I input. On a divide-ratio change request it gates, clears, reloads and re-enables the divided clock in a fixed, glitch-safe order. It also reports when the output clock is stable.

Parameters:
CE_HOLD, 2, cycles CE is held low before CLR asserts (legal 1..255)
CLR_HOLD, 4, cycles CLR is held high while DIV is reloaded (legal 1..255)
SETTLE, 8, cycles after CLR release before CE re-asserts (legal 1..255)
DIV_INIT, 3'd0, DIV value loaded by reset (0 = divide-by-1)

Ports:
CLK  in  1  reference clock; same net as the buffer's I input
RST  in  1  synchronous reset, active-high
EN  in  1  user clock enable; honoured only in RUN
REQ_VALID  in  1  divide-change request valid
REQ_DIV  in  3  requested DIV code; divide ratio = REQ_DIV+1
REQ_READY  out  1  request accepted on an edge where REQ_VALID & REQ_READY are both high
CE  out  1  to buffer CE
CEMASK  out  1  constant 0
CLR  out  1  to buffer CLR
CLRMASK  out  1  constant 0
DIV  out  3  to buffer DIV
LOCKED  out  1  output clock stable at current DIV

Behaviour:
- Reset and clocking: single clock CLK; RST is synchronous and active-high. All outputs are registered, except CEMASK and CLRMASK, which are tied to 0.
- Reset values, while RST is high: state=CLEAR, cnt=0, CE=0, CLR=1, DIV=DIV_INIT, LOCKED=0, REQ_READY=0, pending=DIV_INIT.
- States: RUN, GATE, CLEAR, SETTLE. There is an 8-bit down-counter cnt.
- Time is counted in the first state's cycles, numbered from the first cycle after the transition.
- RUN:
  - LOCKED=1, REQ_READY=1, CLR=0.
  - CE = EN registered, so CE follows EN with 1-cycle latency.
  - On acceptance where REQ_DIV != DIV: capture pending=REQ_DIV and go to GATE.
  - On acceptance where REQ_DIV == DIV: the request is consumed and the state stays in RUN with no glitch on any output.
- GATE:
  - CE=0, CLR=0, LOCKED=0, REQ_READY=0.
  - Lasts exactly CE_HOLD cycles, then goes to CLEAR.
- CLEAR:
  - CLR=1, CE=0, LOCKED=0, REQ_READY=0.
  - DIV=pending from the first CLEAR cycle onward.
  - Lasts exactly CLR_HOLD cycles, then goes to SETTLE.
- SETTLE:
  - CLR=0, CE=0, LOCKED=0, REQ_READY=0.
  - Lasts exactly SETTLE cycles, then goes to RUN.
- Reset release: the CLEAR sequence runs without a request, reloading DIV=DIV_INIT.
- Invariants:
  - DIV changes only while CLR=1.
  - CE=1 never overlaps CLR=1.
  - CE never rises outside RUN.
- Request acceptance latency: GATE starts at the next edge.
  - Total time out of RUN = CE_HOLD + CLR_HOLD + SETTLE cycles (14 at defaults).
- REQ_VALID while REQ_READY=0: ignored, not queued. The requester must hold it until accepted.
- EN changes outside RUN: ignored. On re-entering RUN, CE takes the current EN on the first RUN cycle.
- RST asserted mid-sequence: the next edge applies reset values and the in-flight request is dropped. DIV returns to DIV_INIT, not to pending.
- Simultaneous REQ_VALID and RST: RST wins and the request is not accepted.
- Counter: loaded with HOLD-1 on state entry, decremented each cycle, state exits when it reaches 0. No wrap-around is reachable for legal parameters.

Test Plan:
1. Reset release, defaults, EN=1, RST low at cycle 0 -> CLR=1 for cycles 1-4; CLR=0, CE=0 for cycles 5-12; cycle 13 has LOCKED=1, REQ_READY=1, CE=1, DIV=0.
2. In RUN with DIV=0, pulse REQ_VALID with REQ_DIV=3, accepted at edge t -> CE=0 at t+1..t+2; CLR=1 with DIV=3 at t+3..t+6; SETTLE t+7..t+14; LOCKED=1, CE=1 at t+15.
3. Request with REQ_DIV equal to current DIV=3 -> REQ_READY stays 1, LOCKED stays 1, and CE, CLR, DIV are unchanged for 20 cycles.
4. Assert REQ_VALID with REQ_DIV=5 during CLEAR of a prior request to 2 -> the second request is not accepted until the next RUN; final DIV=2 first, then the full sequence again to DIV=5.
5. Assert RST at t+4 of a 0->6 change -> next edge gives CLR=1, DIV=0, LOCKED=0; after RST release the scenario-1 timing is repeated with DIV=0.
6. Toggle EN 1->0->1 in RUN -> CE follows with 1-cycle lag and LOCKED stays 1. EN=0 during SETTLE gives CE=0 on the first RUN cycle. An assertion bench over the whole run checks the invariants: never CE&CLR, and DIV stable unless CLR=1.

Source files
------------

// File: rtl/bufg_gt_div_ctrl.sv
// ----------------------------------------------------------------------------
// bufg_gt_div_ctrl
//
// Sequences the CE, CLR and DIV inputs of the BUFG_GT clock-buffer model so a
// divide-ratio change never glitches the divided clock. A change first gates
// the clock (CE low), then holds the divider in clear while DIV is reloaded,
// waits for the buffer to settle, and finally re-enables the clock.
// The block runs on the same reference clock that feeds the buffer's I input.
//
// Ports:
//   clk_i        reference clock (same net as buffer I)
//   rst_i        synchronous reset, active-high
//   en_i         user clock enable, honoured only while running
//   req_valid_i  divide-change request valid
//   req_div_i    requested DIV code (ratio = code + 1)
//   req_ready_o  request taken on an edge where valid and ready are both high
//   ce_o         buffer CE
//   cemask_o     buffer CEMASK, tied low
//   clr_o        buffer CLR
//   clrmask_o    buffer CLRMASK, tied low
//   div_o        buffer DIV
//   locked_o     divided clock is stable at the current DIV
// ----------------------------------------------------------------------------
module bufg_gt_div_ctrl #(
    parameter int unsigned CE_HOLD  = 2,
    parameter int unsigned CLR_HOLD = 4,
    parameter int unsigned SETTLE   = 8,
    parameter logic [2:0]  DIV_INIT = 3'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       req_valid_i,
    input  logic [2:0] req_div_i,
    output logic       req_ready_o,
    output logic       ce_o,
    output logic       cemask_o,
    output logic       clr_o,
    output logic       clrmask_o,
    output logic [2:0] div_o,
    output logic       locked_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_GATE,
        ST_CLEAR,
        ST_SETTLE
    } state_t;

    localparam logic [7:0] CE_LOAD     = 8'(CE_HOLD - 1);
    localparam logic [7:0] CLR_LOAD    = 8'(CLR_HOLD - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] pending_q, pending_d;
    logic       rst_entry_q, rst_entry_d;
    logic       ce_q, ce_d;
    logic       clr_q, clr_d;
    logic [2:0] div_q, div_d;
    logic       locked_q, locked_d;
    logic       ready_q, ready_d;

    // Next-state logic. Each hold state loads its counter with HOLD-1 on
    // entry and leaves when the counter has reached zero, so it lasts exactly
    // HOLD cycles. Reset parks the FSM in CLEAR with a zero counter; the
    // rst_entry flag makes the first cycle after reset release act as the
    // CLEAR entry, so the post-reset clear lasts the full CLR_HOLD cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        rst_entry_d = rst_entry_q;
        case (state_q)
            ST_RUN: begin
                // A request for the ratio already in use is simply consumed.
                if (req_valid_i && ready_q && (req_div_i != div_q)) begin
                    pending_d = req_div_i;
                    state_d   = ST_GATE;
                    cnt_d     = CE_LOAD;
                end
            end
            ST_GATE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CLEAR;
                    cnt_d   = CLR_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CLEAR: begin
                if (rst_entry_q) begin
                    rst_entry_d = 1'b0;
                    cnt_d       = CLR_LOAD;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = CLR_LOAD;
            end
        endcase
    end

    // Output decode from the next state, so every buffer control is a flop
    // that changes on the same edge as the state. DIV is only reloaded while
    // the next state is CLEAR, which keeps DIV changes inside the CLR window.
    always_comb begin
        ce_d     = 1'b0;
        clr_d    = 1'b0;
        locked_d = 1'b0;
        ready_d  = 1'b0;
        div_d    = div_q;
        case (state_d)
            ST_RUN: begin
                ce_d     = en_i;
                locked_d = 1'b1;
                ready_d  = 1'b1;
            end
            ST_CLEAR: begin
                clr_d = 1'b1;
                div_d = pending_q;
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= 8'd0;
            pending_q   <= DIV_INIT;
            rst_entry_q <= 1'b1;
            ce_q        <= 1'b0;
            clr_q       <= 1'b1;
            div_q       <= DIV_INIT;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            rst_entry_q <= rst_entry_d;
            ce_q        <= ce_d;
            clr_q       <= clr_d;
            div_q       <= div_d;
            locked_q    <= locked_d;
            ready_q     <= ready_d;
        end
    end

    assign req_ready_o = ready_q;
    assign ce_o        = ce_q;
    assign cemask_o    = 1'b0;
    assign clr_o       = clr_q;
    assign clrmask_o   = 1'b0;
    assign div_o       = div_q;
    assign locked_o    = locked_q;

endmodule
